// File: rtl/navre_io_pkg.sv
// Shared constants for the navre IO input port: default IO addresses,
// FIFO depth and status/control bit positions.
package navre_io_pkg;

  localparam logic [5:0]  DEF_DATA_ADDR  = 6'd43;
  localparam logic [5:0]  DEF_STAT_ADDR  = 6'd44;
  localparam int unsigned DEF_DEPTH_LOG2 = 4;

  localparam int unsigned STAT_NEMPTY = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_UFLOW  = 2;
  localparam int unsigned CTRL_FLUSH  = 7;

  // Assemble the status byte; every bit not listed reads as zero.
  function automatic logic [7:0] status_byte(input logic uflow,
                                             input logic full,
                                             input logic nempty);
    logic [7:0] s;
    s              = 8'h00;
    s[STAT_UFLOW]  = uflow;
    s[STAT_FULL]   = full;
    s[STAT_NEMPTY] = nempty;
    return s;
  endfunction

endpackage

// File: rtl/navre_inport_fifo.sv
// Byte FIFO behind the navre IO input port: storage, pointers, occupancy
// count and a registered ready flag. Flush overrides push and pop.
module navre_inport_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  ready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count == '0);
  assign full  = count[DEPTH_LOG2];
  assign rdata = mem[rd_ptr];

  // Qualify requests: flush wins, no push when full, no pop when empty.
  always_comb begin
    do_push    = push && !full && !flush;
    do_pop     = pop && !empty && !flush;
    count_next = count;
    if (flush)
      count_next = '0;
    else if (do_push && !do_pop)
      count_next = count + CNT_ONE;
    else if (do_pop && !do_push)
      count_next = count - CNT_ONE;
  end

  // Pointer, count and ready state; ready stays low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      ready <= (count_next != CNT_FULL);
    end
  end

  // Data storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/navre_io_inport.sv
// navre CPU IO-bus input port: buffers an upstream byte stream and serves
// it through a data address (read pops) and a status/control address.
// Optional feature: define NAVRE_INPORT_COUNT_EN to map the occupancy
// count at STAT_ADDR+1.
module navre_io_inport
  import navre_io_pkg::*;
#(
  parameter logic [5:0]  DATA_ADDR  = DEF_DATA_ADDR,
  parameter logic [5:0]  STAT_ADDR  = DEF_STAT_ADDR,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [5:0] io_a,
  input  logic [7:0] io_do,
  output logic [7:0] io_di,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready
);

  logic [7:0]          head;
  logic [DEPTH_LOG2:0] count;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                flush;
  logic                uflow_clr;
  logic                data_rd;
  logic                stat_wr;
  logic                underflow;
  logic [7:0]          di_next;

  navre_inport_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (in_data),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full),
    .ready (in_ready)
  );

  // Address decode and read-data selection for the next io_di value.
  always_comb begin
    data_rd   = io_re && (io_a == DATA_ADDR);
    stat_wr   = io_we && (io_a == STAT_ADDR);
    push      = in_valid && in_ready;
    pop       = data_rd && !empty;
    flush     = stat_wr && io_do[CTRL_FLUSH];
    uflow_clr = stat_wr && io_do[STAT_UFLOW];
    di_next   = 8'h00;
    if (data_rd)
      di_next = empty ? 8'h00 : head;
    else if (io_re && (io_a == STAT_ADDR))
      di_next = status_byte(underflow, full, !empty);
`ifdef NAVRE_INPORT_COUNT_EN
    else if (io_re && (io_a == 6'(STAT_ADDR + 6'd1)))
      di_next = 8'(count);
`endif
  end

  // Registered read data and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_di     <= 8'h00;
      underflow <= 1'b0;
    end else begin
      io_di <= di_next;
      if (data_rd && empty)
        underflow <= 1'b1;
      else if (uflow_clr)
        underflow <= 1'b0;
    end
  end

`ifdef NAVRE_INPORT_COUNT_EN
  logic unused_bits;
  assign unused_bits = ^{io_do[6:3], io_do[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{io_do[6:3], io_do[1:0], count};
`endif

endmodule

// File: tb/tb_navre_io_inport.sv
// Randomized and directed bench for navre_io_inport against a queue-based
// model of the port's behaviour.
module tb_navre_io_inport;

  localparam logic [5:0] DA    = 6'd43;
  localparam logic [5:0] SA    = 6'd44;
  localparam int         DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       io_re;
  logic       io_we;
  logic [5:0] io_a;
  logic [7:0] io_do;
  logic [7:0] io_di;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  navre_io_inport dut (
    .clk      (clk),
    .rst      (rst),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_a     (io_a),
    .io_do    (io_do),
    .io_di    (io_di),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic       uf;
  logic       erdy;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h exp %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic re, input logic we,
                      input logic [5:0] a, input logic [7:0] d,
                      input logic v, input logic [7:0] bd);
    logic [7:0] edi;
    int n;
    logic push_ok;
    rst = r; io_re = re; io_we = we; io_a = a; io_do = d;
    in_valid = v; in_data = bd;
    n = q.size();
    if (r) begin
      q.delete();
      uf = 1'b0; edi = 8'h00; erdy = 1'b0;
    end else begin
      push_ok = v && erdy;
      edi = 8'h00;
      if (re && a == DA)
        edi = (n > 0) ? q[0] : 8'h00;
      else if (re && a == SA)
        edi = {5'b0, uf, n == DEPTH, n != 0};
`ifdef NAVRE_INPORT_COUNT_EN
      else if (re && a == SA + 6'd1)
        edi = 8'(n);
`endif
      if (re && a == DA && n == 0) uf = 1'b1;
      else if (we && a == SA && d[2]) uf = 1'b0;
      if (we && a == SA && d[7]) begin
        q.delete();
      end else begin
        if (re && a == DA && n > 0) void'(q.pop_front());
        if (push_ok) q.push_back(bd);
      end
      erdy = (q.size() != DEPTH);
    end
    @(posedge clk);
    @(negedge clk);
    check("io_di", io_di, edi);
    check("in_ready", {7'b0, in_ready}, {7'b0, erdy});
  endtask

  task automatic idle();                       step(0, 0, 0, 6'd0, 8'h00, 0, 8'h00); endtask
  task automatic push(input logic [7:0] b);    step(0, 0, 0, 6'd0, 8'h00, 1, b);     endtask
  task automatic rd(input logic [5:0] a);      step(0, 1, 0, a, 8'h00, 0, 8'h00);    endtask
  task automatic wr(input logic [5:0] a, input logic [7:0] d); step(0, 0, 1, a, d, 0, 8'h00); endtask
  task automatic do_reset();                   step(1, 0, 0, 6'd0, 8'h00, 0, 8'h00); endtask

  initial begin
    rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_a = 6'd0; io_do = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; uf = 1'b0; erdy = 1'b0;

    // Reset state
    do_reset();
    do_reset();
    check("rst_di", io_di, 8'h00);
    check("rst_ready", {7'b0, in_ready}, 8'h00);
    idle();
    check("ready_after_rst", {7'b0, in_ready}, 8'h01);

    // Three bytes in, three out in order, then status clear
    push(8'h11); push(8'h22); push(8'h33);
    rd(DA); check("ord0", io_di, 8'h11);
    rd(DA); check("ord1", io_di, 8'h22);
    rd(DA); check("ord2", io_di, 8'h33);
    rd(SA); check("stat_empty", io_di, 8'h00);

    // Underflow: sticky, cleared by writing bit 2
    rd(DA); check("uflow_data", io_di, 8'h00);
    rd(SA); check("uflow_stat", io_di, 8'h04);
    wr(SA, 8'h04);
    rd(SA); check("uflow_clr", io_di, 8'h00);

    // Fill to full with in_valid held, then one pop frees a slot
    for (int i = 0; i < DEPTH + 2; i++) push(8'(8'hA0 + i));
    check("full_ready", {7'b0, in_ready}, 8'h00);
    rd(SA); check("stat_full", io_di, 8'h03);
    rd(DA); check("full_pop", io_di, 8'hA0);
    check("ready_after_pop", {7'b0, in_ready}, 8'h01);
    wr(SA, 8'h80);

    // Push and pop together at count 5
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    step(0, 1, 0, DA, 8'h00, 1, 8'h55);
    check("pp_head", io_di, 8'h50);
`ifdef NAVRE_INPORT_COUNT_EN
    rd(SA + 6'd1); check("pp_count", io_di, 8'h05);
`endif
    for (int i = 1; i < 6; i++) begin
      rd(DA); check("pp_order", io_di, 8'(8'h50 + i));
    end

    // Flush with concurrent push discards everything
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    step(0, 0, 1, SA, 8'h80, 1, 8'h77);
    rd(SA); check("flush_stat", io_di, 8'h00);
    rd(DA); check("flush_data", io_di, 8'h00);
    wr(SA, 8'h04);

    // Reset mid-operation with 6 bytes buffered
    for (int i = 0; i < 6; i++) push(8'(8'h70 + i));
    do_reset();
    check("mid_rst_di", io_di, 8'h00);
    idle();
    check("mid_rst_ready", {7'b0, in_ready}, 8'h01);
    rd(SA); check("mid_rst_stat", io_di, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] a;
      logic [7:0] d;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = DA - 6'd1;
        1, 2: a = DA;
        3: a = SA;
        4: a = SA + 6'd1;
        default: a = 6'($urandom);
      endcase
      d = 8'($urandom);
      if ($urandom_range(0, 99) < 2)
        do_reset();
      else if ($urandom_range(0, 9) == 0)
        step(0, 0, 1, a, ($urandom_range(0, 3) == 0) ? d : (d & 8'h7F),
             1'($urandom), 8'($urandom));
      else
        step(0, 1'($urandom_range(0, 2) != 0), 0, a, 8'h00,
             1'($urandom_range(0, 3) != 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
